// File: rtl/matrix_feeder_if.sv
// matrix_feeder_if: operand/result handshake bus between the feeder and the 2x2 multiplier.
interface matrix_feeder_if;
    logic [31:0] output_A11, output_A12, output_A21, output_A22;
    logic [31:0] output_B11, output_B12, output_B21, output_B22;
    logic        output_Stable;
    logic        output_C_Ack;
    logic        input_AB_Ack;
    logic        input_Stable;
    logic        input_Free;
    logic [31:0] input_C11, input_C12, input_C21, input_C22;

    modport master (
        output output_A11, output_A12, output_A21, output_A22,
        output output_B11, output_B12, output_B21, output_B22,
        output output_Stable, output_C_Ack,
        input  input_AB_Ack, input_Stable, input_Free,
        input  input_C11, input_C12, input_C21, input_C22
    );

    modport slave (
        input  output_A11, output_A12, output_A21, output_A22,
        input  output_B11, output_B12, output_B21, output_B22,
        input  output_Stable, output_C_Ack,
        output input_AB_Ack, input_Stable, input_Free,
        output input_C11, input_C12, input_C21, input_C22
    );
endinterface

// File: rtl/matrix_feeder.sv
// matrix_feeder: host operand bank and handshake sequencer for an external 2x2 FP matrix multiplier.
module matrix_feeder #(
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic            input_Clk,
    input  logic            input_Reset,
    input  logic            input_Wr_En,
    input  logic [2:0]      input_Wr_Addr,
    input  logic [31:0]     input_Wr_Data,
    input  logic            input_Start,
    input  logic            input_Done_Ack,
    output logic            output_Busy,
    output logic            output_Done,
    output logic            output_Error,
    output logic [15:0]     output_Latency,
    output logic [31:0]     output_R11,
    output logic [31:0]     output_R12,
    output logic [31:0]     output_R21,
    output logic [31:0]     output_R22,
    matrix_feeder_if.master mul
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT_RES, ACK, DONE} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_bank [8];
    logic [31:0] r_res [4];
    logic        r_stable, r_c_ack, r_done, r_err;
    logic [15:0] r_lat;
    logic        w_run, w_start, w_exit, w_timeout;

    always_comb begin
        w_run     = (r_state == REQ) || (r_state == WAIT_RES);
        w_start   = (r_state == IDLE) && input_Start && mul.input_Free;
        w_exit    = (r_state == REQ) ? mul.input_AB_Ack : (r_state == WAIT_RES) && mul.input_Stable;
        w_timeout = w_run && !w_exit && (r_lat == TIMEOUT);
        w_next    = r_state;
        case (r_state)
            IDLE:     w_next = w_start ? REQ : IDLE;
            REQ:      w_next = w_exit ? WAIT_RES : w_timeout ? DONE : REQ;
            WAIT_RES: w_next = w_exit ? ACK : w_timeout ? DONE : WAIT_RES;
            ACK:      w_next = (mul.input_Free && !mul.input_Stable) ? DONE : ACK;
            DONE:     w_next = input_Done_Ack ? IDLE : DONE;
            default:  w_next = IDLE;
        endcase
    end

    // handshake levels are registered from the next state so each is a clean flop output
    always_ff @(posedge input_Clk) begin
        if (input_Reset) begin
            r_state  <= IDLE;
            r_stable <= 1'b0;
            r_c_ack  <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_lat    <= '0;
            for (int i = 0; i < 8; i++) r_bank[i] <= '0;
            for (int i = 0; i < 4; i++) r_res[i] <= '0;
        end else begin
            r_state  <= w_next;
            r_stable <= w_next == REQ;
            r_c_ack  <= w_next == ACK;
            r_done   <= w_next == DONE;
            if (r_state == IDLE && input_Wr_En) r_bank[input_Wr_Addr] <= input_Wr_Data;
            if (w_start) begin
                r_lat <= '0;
                r_err <= 1'b0;
            end else if (w_run && !w_timeout) begin
                r_lat <= r_lat + {15'd0, r_lat != 16'hFFFF};
            end
            if (w_timeout) r_err <= 1'b1;
            if (r_state == WAIT_RES && mul.input_Stable) begin
                r_res[0] <= mul.input_C11;
                r_res[1] <= mul.input_C12;
                r_res[2] <= mul.input_C21;
                r_res[3] <= mul.input_C22;
            end
        end
    end

    assign output_Busy       = r_state != IDLE;
    assign output_Done       = r_done;
    assign output_Error      = r_err;
    assign output_Latency    = r_lat;
    assign output_R11        = r_res[0];
    assign output_R12        = r_res[1];
    assign output_R21        = r_res[2];
    assign output_R22        = r_res[3];
    assign mul.output_Stable = r_stable;
    assign mul.output_C_Ack  = r_c_ack;
    assign mul.output_A11    = r_bank[0];
    assign mul.output_A12    = r_bank[1];
    assign mul.output_A21    = r_bank[2];
    assign mul.output_A22    = r_bank[3];
    assign mul.output_B11    = r_bank[4];
    assign mul.output_B12    = r_bank[5];
    assign mul.output_B21    = r_bank[6];
    assign mul.output_B22    = r_bank[7];
endmodule

// File: tb/tb_matrix_feeder.sv
// tb_matrix_feeder: directed checks of the feeder against a scripted multiplier.
module tb_matrix_feeder;
    logic        clk = 1'b0;
    logic        rst, wr_en, start, done_ack;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy, done, err;
    logic [15:0] lat;
    logic [31:0] r11, r12, r21, r22;
    int          total = 0;
    int          bad = 0;
    int          n;

    matrix_feeder_if mif();

    matrix_feeder #(.TIMEOUT(16'd20)) dut (
        .input_Clk(clk), .input_Reset(rst), .input_Wr_En(wr_en), .input_Wr_Addr(wr_addr),
        .input_Wr_Data(wr_data), .input_Start(start), .input_Done_Ack(done_ack),
        .output_Busy(busy), .output_Done(done), .output_Error(err), .output_Latency(lat),
        .output_R11(r11), .output_R12(r12), .output_R21(r21), .output_R22(r22), .mul(mif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        int k;
        @(negedge clk);
        k = int'(mif.output_Stable) + int'(mif.output_C_Ack) + int'(done);
        check("excl", 32'(k <= 1), 32'd1);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic to_ack(input int ack_n, input int res_n, input logic [31:0] c0, c1, c2, c3);
        start = 1'b1; mif.input_Free = 1'b1;
        tick();
        start = 1'b0; wr_en = 1'b0; mif.input_Free = 1'b0;
        check("req_stable", mif.output_Stable, 1);
        check("req_busy", busy, 1);
        check("req_done", done, 0);
        for (int i = 1; i <= ack_n; i++) begin
            mif.input_AB_Ack = (i == ack_n);
            tick();
        end
        mif.input_AB_Ack = 1'b0;
        check("wait_stable", mif.output_Stable, 0);
        for (int i = 1; i <= res_n; i++) begin
            if (i == res_n) begin
                mif.input_Stable = 1'b1;
                mif.input_C11 = c0; mif.input_C12 = c1; mif.input_C21 = c2; mif.input_C22 = c3;
            end
            tick();
        end
        check("ack_cack", mif.output_C_Ack, 1);
    endtask

    task automatic finish_ack();
        tick();
        check("ack_hold", mif.output_C_Ack, 1);
        check("ack_nodone", done, 0);
        mif.input_Stable = 1'b0; mif.input_Free = 1'b1;
        tick();
        check("done_set", done, 1);
        check("done_cack", mif.output_C_Ack, 0);
        check("done_stable", mif.output_Stable, 0);
    endtask

    task automatic ack_done();
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; start = 1'b0; done_ack = 1'b0; wr_addr = '0; wr_data = '0;
        mif.input_AB_Ack = 1'b0; mif.input_Stable = 1'b0; mif.input_Free = 1'b1;
        mif.input_C11 = '0; mif.input_C12 = '0; mif.input_C21 = '0; mif.input_C22 = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_lat", lat, 0);
        check("rst_stable", mif.output_Stable, 0);
        check("rst_r11", r11, 0);
        check("rst_a11", mif.output_A11, 0);

        wr(3'd0, 32'h3F800000); wr(3'd1, 32'h40000000); wr(3'd2, 32'h40400000);
        wr(3'd4, 32'h3F800000); wr(3'd7, 32'h3F800000);
        check("bank_a12", mif.output_A12, 32'h40000000);
        check("bank_b11", mif.output_B11, 32'h3F800000);
        check("bank_b12", mif.output_B12, 32'h00000000);

        mif.input_Free = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("nofree_busy", busy, 0);
        check("nofree_stable", mif.output_Stable, 0);

        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'h40800000;
        to_ack(2, 10, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
        check("a22_new", mif.output_A22, 32'h40800000);
        finish_ack();
        check("r11", r11, 32'h3F800000);
        check("r12", r12, 32'h40000000);
        check("r21", r21, 32'h40400000);
        check("r22", r22, 32'h40800000);
        check("run_err", err, 0);
        check("run_lat", lat, 12);
        for (int i = 0; i < 50; i++) tick();
        check("hold_done", done, 1);
        check("hold_r22", r22, 32'h40800000);
        ack_done();
        check("idle_lat", lat, 12);
        check("idle_r11", r11, 32'h3F800000);

        start = 1'b1; mif.input_Free = 1'b1;
        tick();
        start = 1'b0; mif.input_Free = 1'b0; mif.input_AB_Ack = 1'b1;
        tick();
        mif.input_AB_Ack = 1'b0;
        check("to_wait_stable", mif.output_Stable, 0);
        wr(3'd5, 32'hDEADBEEF);
        check("busy_wr_b12", mif.output_B12, 32'h00000000);
        n = 2;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check("to_cycles", n, 21);
        check("to_lat", lat, 20);
        check("to_err", err, 1);
        check("to_stable", mif.output_Stable, 0);
        check("to_r11", r11, 32'h3F800000);
        check("to_r22", r22, 32'h40800000);
        mif.input_Free = 1'b1;
        ack_done();
        check("to_err_hold", err, 1);
        wr(3'd5, 32'hDEADBEEF);
        check("idle_wr_b12", mif.output_B12, 32'hDEADBEEF);

        to_ack(1, 3, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        rst = 1'b1;
        tick();
        rst = 1'b0; mif.input_Stable = 1'b0; mif.input_Free = 1'b1;
        check("ackrst_busy", busy, 0);
        check("ackrst_cack", mif.output_C_Ack, 0);
        check("ackrst_done", done, 0);
        check("ackrst_err", err, 0);
        check("ackrst_lat", lat, 0);
        check("ackrst_a11", mif.output_A11, 0);
        check("ackrst_b12", mif.output_B12, 0);
        check("ackrst_r11", r11, 0);

        wr(3'd0, 32'h3F800000); wr(3'd1, 32'h40000000); wr(3'd2, 32'h40400000);
        wr(3'd3, 32'h40800000); wr(3'd4, 32'h40000000); wr(3'd7, 32'h40000000);
        to_ack(1, 3, 32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000);
        finish_ack();
        check("r2_r11", r11, 32'h40000000);
        check("r2_r12", r12, 32'h40800000);
        check("r2_r21", r21, 32'h40C00000);
        check("r2_r22", r22, 32'h41000000);
        check("r2_lat", lat, 4);
        check("r2_err", err, 0);
        ack_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/matrix_feeder.md
MATRIX_FEEDER -- requirements
Module: matrix_feeder

Interface
REQ-001 Parameter TIMEOUT, default 16'd1000: max cycles spent in REQ+WAIT_RES before an abort.
REQ-002 input_Clk  in  1  single clock; all state updates on rising edge.
REQ-003 input_Reset  in  1  synchronous, active-high reset.
REQ-004 input_Wr_En  in  1  host operand write strobe.
REQ-005 input_Wr_Addr  in  3  0..3 = A11,A12,A21,A22; 4..7 = B11,B12,B21,B22.
REQ-006 input_Wr_Data  in  32  IEEE-754 single operand.
REQ-007 input_Start  in  1  host request to run one 2x2 product.
REQ-008 input_Done_Ack  in  1  host acknowledges the result.
REQ-009 output_Busy  out  1  high in every state except IDLE.
REQ-010 output_Done  out  1  result/abort available to host.
REQ-011 output_Error  out  1  last run aborted by timeout.
REQ-012 output_Latency  out  16  cycle count of last run.
REQ-013 output_R11, output_R12, output_R21, output_R22  out  32 each  captured product matrix.
REQ-014 output_A11..output_A22, output_B11..output_B22  out  32 each  operand bank to multiplier.
REQ-015 output_Stable  out  1  operands valid request to multiplier.
REQ-016 input_AB_Ack  in  1  multiplier accepted operands.
REQ-017 input_Stable  in  1  multiplier result valid (level).
REQ-018 input_C11..input_C22  in  32 each  multiplier result.
REQ-019 output_C_Ack  out  1  result consumed, to multiplier.
REQ-020 input_Free  in  1  multiplier idle.

Function
REQ-021 FSM states: IDLE, REQ, WAIT_RES, ACK, DONE.
REQ-022 Operand bank: Wr_En in IDLE writes the addressed register next edge; writes in any other state are ignored; operand outputs are driven directly from the bank and stay constant from Start acceptance through DONE.
REQ-023 IDLE -> REQ when input_Start=1 and input_Free=1; Start with Free=0 or outside IDLE is dropped, not queued.
REQ-024 Start and Wr_En in the same IDLE cycle: the write is committed and the run uses the new value.
REQ-025 On Start acceptance: output_Latency<=0, output_Error<=0, output_Done<=0.
REQ-026 REQ: output_Stable=1; on the first cycle input_AB_Ack=1 -> WAIT_RES, output_Stable=0 from the next cycle.
REQ-027 WAIT_RES: on input_Stable=1, capture input_C11..C22 into output_R11..R22 that edge -> ACK.
REQ-028 ACK: output_C_Ack=1; -> DONE when input_Free=1 and input_Stable=0; C_Ack deasserts on entering DONE.
REQ-029 DONE: output_Done=1; on input_Done_Ack=1 -> IDLE, Done=0 next cycle; R, Error and Latency hold until the next accepted Start.
REQ-030 output_Latency increments by 1 on every cycle spent in REQ or WAIT_RES, saturating at 16'hFFFF.
REQ-031 Timeout: in REQ or WAIT_RES, when Latency equals TIMEOUT and no exit event occurs that cycle -> DONE with output_Error=1 and output_Stable=0; R registers are not updated.
REQ-032 Exit event and timeout in the same cycle: the exit event wins and no error is flagged.
REQ-033 output_Stable, output_C_Ack and output_Done are registered, glitch-free levels; at most one of them is high in any cycle.

Reset
REQ-034 input_Reset=1 at a clock edge forces, from any state including mid-run: state=IDLE, Stable=0, C_Ack=0, Done=0, Error=0, Busy=0, Latency=0, all operand and R registers=0.
REQ-035 Reset overrides Start, Wr_En and every handshake input in the same cycle.

Verification
REQ-036 Write A=[3F800000,40000000;40400000,40800000], B=identity, Start, behavioural multiplier (ack after 2, result after 10 cycles) -> R=[3F800000,40000000;40400000,40800000], Done=1, Error=0, Latency=12.
REQ-037 Start while input_Free=0 -> stays IDLE, Busy=0; a later Start with Free=1 runs normally.
REQ-038 Multiplier never raises input_Stable, TIMEOUT=20 -> DONE at Latency=20, Error=1, R unchanged from the previous run, Stable=0.
REQ-039 Wr_En to addr 5 with 0xDEADBEEF while in WAIT_RES -> output_B12 unchanged; the same write in IDLE -> output_B12=0xDEADBEEF next cycle.
REQ-040 Assert input_Reset during ACK -> next cycle IDLE, C_Ack=0, all outputs at reset values; the following run completes correctly.
REQ-041 Hold input_Done_Ack low for 50 cycles in DONE -> Done stays 1 and R stable; Ack=1 -> IDLE, Done=0 next cycle.
